// File: rtl/seq_restoring_divider_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_restoring_divider_if
//  Purpose  : Start/done handshake and operand/result bundle for the
//             sequential restoring divider.
//  Signals  : start        request, honoured only while ready=1
//             dividend     DW-bit dividend, sampled on the accepting edge
//             divisor      VW-bit divisor, sampled on the accepting edge
//             ready        divider idle and able to accept
//             done         one-cycle pulse, results valid
//             quotient     DW-bit result, held until the next accept
//             remainder    VW-bit result, held until the next accept
//             div_by_zero  set with done when divisor was zero
//  Modports : master (requester), slave (divider)
//  Revision : 1.0  initial release
// ============================================================================
interface seq_restoring_divider_if #(
    parameter int DW = 8,
    parameter int VW = 4
);
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          ready;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  ready, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, done, quotient, remainder, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module   : seq_restoring_divider
//  Purpose  : Sequential restoring divider, one quotient bit per clock.
//             Divides a DW-bit dividend by a VW-bit divisor giving a DW-bit
//             quotient and a VW-bit remainder behind a start/done handshake.
//  Ports    : clk  rising-edge clock
//             rst  asynchronous, active-high reset
//             bus  seq_restoring_divider_if.slave (handshake, operands,
//                  results, divide-by-zero flag)
//  Revision : 1.0  initial release
// ============================================================================
module seq_restoring_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    seq_restoring_divider_if.slave    bus
);

    localparam int            CW   = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [DW-1:0] dvd_q;        // dividend, shifted left one bit per step
    logic [VW-1:0] dvs_q;        // latched divisor
    logic [VW:0]   rem_q;        // partial remainder, one bit wider than divisor
    logic [DW-1:0] quo_acc_q;    // quotient under construction
    logic [CW-1:0] cnt_q;        // step index 0..DW-1
    logic          dbz_pend_q;   // current operation is a divide by zero
    logic          ready_q;
    logic          done_q;
    logic [DW-1:0] quotient_q;
    logic [VW-1:0] remainder_q;
    logic          dbz_q;

    // One restoring step: bring in the next dividend bit, trial-subtract,
    // keep the difference only if it did not go negative.
    logic [VW:0]   rem_shift;
    logic          qbit;
    logic [VW:0]   rem_d;
    logic [DW-1:0] quo_d;

    always_comb begin
        rem_shift = {rem_q[VW-1:0], dvd_q[DW-1]};
        qbit      = (rem_shift >= {1'b0, dvs_q});
        rem_d     = qbit ? (rem_shift - {1'b0, dvs_q}) : rem_shift;
        quo_d     = {quo_acc_q[DW-2:0], qbit};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_acc_q   <= '0;
            cnt_q       <= '0;
            dbz_pend_q  <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q   <= S_CALC;
                        ready_q   <= 1'b0;
                        dbz_q     <= 1'b0;
                        dvd_q     <= bus.dividend;
                        dvs_q     <= bus.divisor;
                        rem_q     <= '0;
                        quo_acc_q <= '0;
                        if (bus.divisor == '0) begin
                            // Divide by zero spends a single dummy step so
                            // its result is reported through the same
                            // DONE-entry edge as a normal divide, one edge
                            // after the accept.
                            dbz_pend_q <= 1'b1;
                            cnt_q      <= LAST;
                        end else begin
                            dbz_pend_q <= 1'b0;
                            cnt_q      <= '0;
                        end
                    end
                end

                S_CALC: begin
                    dvd_q     <= {dvd_q[DW-2:0], 1'b0};
                    rem_q     <= rem_d;
                    quo_acc_q <= quo_d;
                    cnt_q     <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        if (dbz_pend_q) begin
                            quotient_q  <= {DW{1'b1}};
                            remainder_q <= '0;
                            dbz_q       <= 1'b1;
                        end else begin
                            quotient_q  <= quo_d;
                            remainder_q <= rem_d[VW-1:0];
                            dbz_q       <= 1'b0;
                        end
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end

                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready       = ready_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_restoring_divider
//  Purpose  : Self-checking bench for seq_restoring_divider: directed vector
//             table, start-during-CALC, async reset mid-CALC, full sweep.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_restoring_divider;

    localparam int DW = 8;
    localparam int VW = 4;

    logic clk;
    logic rst;

    int n_tests;
    int n_fail;

    seq_restoring_divider_if #(.DW(DW), .VW(VW)) bus ();

    seq_restoring_divider #(.DW(DW), .VW(VW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] dvd;
        logic [VW-1:0] dvs;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          z;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int w;
        w = 0;
        while (!bus.ready && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 40) chk("wait_ready_timeout", 0, 1);
    endtask

    // Issue one divide and collect the result. Called with time at #1 after
    // a rising edge. lat = number of edges after the accepting edge until
    // done is first seen; returns one sample after the done cycle.
    task automatic do_div(input logic [DW-1:0] a, input logic [VW-1:0] b,
                          output logic [DW-1:0] q, output logic [VW-1:0] r,
                          output logic z, output int lat,
                          output logic rdy_low_ok, output logic after_ok,
                          output logic got_done);
        wait_ready();
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        lat        = 0;
        rdy_low_ok = 1'b1;
        while (!bus.done && lat < 20) begin
            if (bus.ready) rdy_low_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        got_done = bus.done;
        if (!bus.done) chk("done_timeout", 0, 1);
        if (bus.ready) rdy_low_ok = 1'b0;
        q = bus.quotient;
        r = bus.remainder;
        z = bus.div_by_zero;
        @(posedge clk); #1;
        after_ok = !bus.done && bus.ready && (bus.quotient == q) && (bus.remainder == r);
    endtask

    initial begin
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          z;
        logic          rl_ok;
        logic          af_ok;
        logic          gd;
        int            lat;
        int            ndone;
        int            nacc;

        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{dvd: 8'd50,  dvs: 4'd5,  q: 8'd10,  r: 4'd0,  z: 1'b0};
        vecs[1] = '{dvd: 8'd200, dvs: 4'd7,  q: 8'd28,  r: 4'd4,  z: 1'b0};
        vecs[2] = '{dvd: 8'd225, dvs: 4'd15, q: 8'd15,  r: 4'd0,  z: 1'b0};
        vecs[3] = '{dvd: 8'd3,   dvs: 4'd9,  q: 8'd0,   r: 4'd3,  z: 1'b0};
        vecs[4] = '{dvd: 8'd255, dvs: 4'd1,  q: 8'd255, r: 4'd0,  z: 1'b0};
        vecs[5] = '{dvd: 8'd100, dvs: 4'd0,  q: 8'hFF,  r: 4'd0,  z: 1'b1};
        vecs[6] = '{dvd: 8'd60,  dvs: 4'd4,  q: 8'd15,  r: 4'd0,  z: 1'b0};
        vecs[7] = '{dvd: 8'd0,   dvs: 4'd3,  q: 8'd0,   r: 4'd0,  z: 1'b0};
        vecs[8] = '{dvd: 8'd254, dvs: 4'd15, q: 8'd16,  r: 4'd14, z: 1'b0};
        vecs[9] = '{dvd: 8'd255, dvs: 4'd15, q: 8'd17,  r: 4'd0,  z: 1'b0};

        // Reset state
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #2;
        chk("reset_ready",     int'(bus.ready),       1);
        chk("reset_done",      int'(bus.done),        0);
        chk("reset_quotient",  int'(bus.quotient),    0);
        chk("reset_remainder", int'(bus.remainder),   0);
        chk("reset_dbz",       int'(bus.div_by_zero), 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            do_div(vecs[i].dvd, vecs[i].dvs, q, r, z, lat, rl_ok, af_ok, gd);
            chk($sformatf("vec%0d_quotient", i),  int'(q), int'(vecs[i].q));
            chk($sformatf("vec%0d_remainder", i), int'(r), int'(vecs[i].r));
            chk($sformatf("vec%0d_dbz", i),       int'(z), int'(vecs[i].z));
            chk($sformatf("vec%0d_latency", i),   lat, vecs[i].z ? 1 : DW);
            chk($sformatf("vec%0d_ready_low", i), int'(rl_ok), 1);
            chk($sformatf("vec%0d_after_done", i), int'(af_ok), 1);
        end

        // start with new operands during CALC is ignored
        wait_ready();
        bus.dividend = 8'd200;
        bus.divisor  = 4'd7;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        ndone = 0;
        q = '0;
        r = '0;
        for (int i = 0; i < 20; i++) begin
            if (i == 2) begin
                bus.start    = 1'b1;
                bus.dividend = 8'd50;
                bus.divisor  = 4'd5;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            if (bus.done) begin
                ndone++;
                q = bus.quotient;
                r = bus.remainder;
            end
        end
        bus.start = 1'b0;
        chk("ignore_done_count", ndone,  1);
        chk("ignore_quotient",   int'(q), 28);
        chk("ignore_remainder",  int'(r), 4);

        // Asynchronous reset mid-CALC
        wait_ready();
        bus.dividend = 8'd200;
        bus.divisor  = 4'd7;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_quotient",  int'(bus.quotient),  0);
        chk("arst_remainder", int'(bus.remainder), 0);
        chk("arst_ready",     int'(bus.ready),     1);
        chk("arst_done",      int'(bus.done),      0);
        @(posedge clk);
        #3 rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        chk("arst_no_done", ndone, 0);
        do_div(8'd60, 4'd4, q, r, z, lat, rl_ok, af_ok, gd);
        chk("arst_next_quotient",  int'(q), 15);
        chk("arst_next_remainder", int'(r), 0);

        // Sweep every dividend against every non-zero divisor
        nacc  = 0;
        ndone = 0;
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                do_div(DW'(a), VW'(b), q, r, z, lat, rl_ok, af_ok, gd);
                nacc++;
                if (gd) ndone++;
                chk($sformatf("sweep_q_%0d_%0d", a, b), int'(q), a / b);
                chk($sformatf("sweep_r_%0d_%0d", a, b), int'(r), a % b);
            end
        end
        chk("sweep_done_count", ndone, nacc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
